// File: rtl/buffer_access_ctrl.sv
// Purpose: owns the 64-byte endpoint buffer, arbitrating USB RX, AHB and USB TX strobes by direction state.
// Latency: gated strobes are combinational; clear and ahb_err are registered one-cycle pulses.
// Backpressure: ahb_ready drops for one cooldown cycle after each granted AHB access; illegal accesses raise ahb_err.
module buffer_access_ctrl #(
    parameter int BUFFER_DEPTH = 64,
    parameter int OCC_W        = 7
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             rx_store_req,
    input  logic             rx_packet_done,
    input  logic             rx_packet_err,
    input  logic             ahb_read_req,
    input  logic             ahb_write_req,
    input  logic [1:0]       ahb_size,
    input  logic             ahb_flush,
    input  logic             tx_start,
    input  logic             tx_get_req,
    input  logic             tx_packet_done,
    input  logic [OCC_W-1:0] buffer_occupancy,
    output logic             store_rx_packet_data,
    output logic             get_rx_data,
    output logic             store_tx_data,
    output logic             get_tx_packet_data,
    output logic [1:0]       data_size,
    output logic             buffer_reserved,
    output logic             clear,
    output logic             rx_data_ready,
    output logic             tx_data_ready,
    output logic             nak,
    output logic             ahb_ready,
    output logic             ahb_err
);

    typedef enum logic [2:0] {
        IDLE,
        RX_FILL,
        RX_HOLD,
        TX_FILL,
        TX_DRAIN
    } state_t;

    localparam int EXT_W = OCC_W + 2;
    localparam logic [EXT_W-1:0] DEPTH_EXT = EXT_W'(BUFFER_DEPTH);

    state_t state_q, state_d;
    logic   cool_q, cool_d;
    logic   ovf_q, ovf_d;
    logic   clear_d;
    logic   err_d;
    logic   grant;

    // Byte arithmetic is done two bits wider so occupancy + access size cannot wrap.
    logic [EXT_W-1:0] occ_ext;
    logic [EXT_W-1:0] access_bytes;
    logic             wr_fits;
    logic             rd_avail;
    logic             occ_full;
    logic             occ_empty;
    logic             ahb_live;
    logic             ahb_req;

    assign occ_ext      = EXT_W'(buffer_occupancy);
    assign access_bytes = EXT_W'(ahb_size) + EXT_W'(1);
    assign wr_fits      = (occ_ext + access_bytes) <= DEPTH_EXT;
    assign rd_avail     = occ_ext >= access_bytes;
    assign occ_full     = occ_ext >= DEPTH_EXT;
    assign occ_empty    = (buffer_occupancy == '0);
    // During cooldown the occupancy may be stale, so AHB requests are ignored outright.
    assign ahb_live     = !cool_q;
    assign ahb_req      = ahb_read_req | ahb_write_req;

    assign data_size = ahb_size;
    assign ahb_ready = !cool_q;

    // State, cooldown, overflow and the registered pulse outputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            cool_q  <= 1'b0;
            ovf_q   <= 1'b0;
            clear   <= 1'b0;
            ahb_err <= 1'b0;
        end else begin
            state_q <= state_d;
            cool_q  <= cool_d;
            ovf_q   <= ovf_d;
            clear   <= clear_d;
            ahb_err <= err_d;
        end
    end

    // Next-state, strobe gating and status decode.
    always_comb begin
        state_d              = state_q;
        ovf_d                = ovf_q;
        clear_d              = 1'b0;
        err_d                = 1'b0;
        grant                = 1'b0;
        store_rx_packet_data = 1'b0;
        get_rx_data          = 1'b0;
        store_tx_data        = 1'b0;
        get_tx_packet_data   = 1'b0;
        buffer_reserved      = 1'b0;
        rx_data_ready        = 1'b0;
        tx_data_ready        = 1'b0;
        nak                  = 1'b0;

        if (ahb_flush) begin
            // Flush overrides anything else requested this cycle.
            state_d = IDLE;
            clear_d = 1'b1;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rx_store_req) begin
                        // RX wins a tie with an AHB write.
                        store_rx_packet_data = 1'b1;
                        state_d              = RX_FILL;
                        err_d                = ahb_live && ahb_req;
                    end else if (ahb_live && ahb_write_req && !ahb_read_req && wr_fits) begin
                        store_tx_data = 1'b1;
                        grant         = 1'b1;
                        state_d       = TX_FILL;
                    end else begin
                        err_d = ahb_live && ahb_req;
                    end
                end
                RX_FILL: begin
                    nak   = 1'b1;
                    err_d = ahb_live && ahb_req;
                    if (rx_store_req) begin
                        if (!occ_full) begin
                            store_rx_packet_data = 1'b1;
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end
                    if (rx_packet_err || (rx_packet_done && (ovf_q || (rx_store_req && occ_full)))) begin
                        clear_d = 1'b1;
                        ovf_d   = 1'b0;
                        state_d = IDLE;
                    end else if (rx_packet_done) begin
                        state_d = RX_HOLD;
                    end
                end
                RX_HOLD: begin
                    rx_data_ready = 1'b1;
                    nak           = 1'b1;
                    if (ahb_live) begin
                        if (ahb_write_req) begin
                            err_d = 1'b1;
                        end else if (ahb_read_req) begin
                            if (rd_avail) begin
                                get_rx_data = 1'b1;
                                grant       = 1'b1;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        if (occ_empty) begin
                            state_d = IDLE;
                        end
                    end
                end
                TX_FILL: begin
                    buffer_reserved = 1'b1;
                    nak             = 1'b1;
                    tx_data_ready   = !occ_empty;
                    if (ahb_live) begin
                        if (ahb_read_req) begin
                            err_d = 1'b1;
                        end else if (ahb_write_req) begin
                            if (wr_fits) begin
                                store_tx_data = 1'b1;
                                grant         = 1'b1;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                    end
                    if (tx_start && !occ_empty) begin
                        state_d = TX_DRAIN;
                    end
                end
                TX_DRAIN: begin
                    buffer_reserved    = 1'b1;
                    nak                = 1'b1;
                    err_d              = ahb_live && ahb_req;
                    // Underrun fetches are dropped without signalling.
                    get_tx_packet_data = tx_get_req && !occ_empty;
                    if (tx_packet_done) begin
                        clear_d = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
        cool_d = grant;
    end

endmodule
